// File: rtl/alu_operand_loader_if.sv
// rtl/alu_operand_loader_if.sv - operand/select capture bus and issued-operation handshake
interface alu_operand_loader_if #(
    parameter int WIDTH   = 4,
    parameter int SEL_W   = 4,
    parameter int COUNT_W = 8
);
    logic [WIDTH-1:0]   din;
    logic               load;
    logic               abort;
    logic               op_ready;
    logic [WIDTH-1:0]   a_out;
    logic [WIDTH-1:0]   b_out;
    logic [SEL_W-1:0]   sel_out;
    logic               op_valid;
    logic               busy;
    logic [1:0]         phase;
    logic               overrun;
    logic [COUNT_W-1:0] op_count;

    modport master (
        output din, load, abort, op_ready,
        input  a_out, b_out, sel_out, op_valid, busy, phase, overrun, op_count
    );

    modport slave (
        input  din, load, abort, op_ready,
        output a_out, b_out, sel_out, op_valid, busy, phase, overrun, op_count
    );
endinterface

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - three-strobe operand capture with registered valid/ready issue
module alu_operand_loader #(
    parameter int WIDTH   = 4,
    parameter int SEL_W   = 4,  // must not exceed WIDTH; taken from the low din bits
    parameter int COUNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    alu_operand_loader_if.slave bus
);
    typedef enum logic [1:0] {
        S_A     = 2'b00,
        S_B     = 2'b01,
        S_SEL   = 2'b10,
        S_ISSUE = 2'b11
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   hold_a;
    logic [WIDTH-1:0]   hold_b;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [SEL_W-1:0]   sel_q;
    logic               valid_q;
    logic               overrun_q;
    logic [COUNT_W-1:0] count_q;

    // Capture sequence, issue handshake, drop detection and completed-op counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_A;
            hold_a    <= '0;
            hold_b    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            overrun_q <= 1'b0;
            case (state)
                S_A: begin
                    if (bus.abort) begin
                        state <= S_A;
                    end else if (bus.load) begin
                        hold_a <= bus.din;
                        state  <= S_B;
                    end
                end
                S_B: begin
                    if (bus.abort) begin
                        state <= S_A;
                    end else if (bus.load) begin
                        hold_b <= bus.din;
                        state  <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (bus.abort) begin
                        state <= S_A;
                    end else if (bus.load) begin
                        a_q     <= hold_a;
                        b_q     <= hold_b;
                        sel_q   <= bus.din[SEL_W-1:0];
                        valid_q <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The operation is committed here: abort has no effect and any
                    // load is dropped and flagged.
                    if (bus.load) begin
                        overrun_q <= 1'b1;
                    end
                    if (valid_q && bus.op_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 1'b1;
                        state   <= S_A;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    assign bus.a_out    = a_q;
    assign bus.b_out    = b_q;
    assign bus.sel_out  = sel_q;
    assign bus.op_valid = valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.op_count = count_q;
    assign bus.phase    = state;
    assign bus.busy     = (state != S_A);
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - randomized and directed bench with behavioural model
module tb_alu_operand_loader;
    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    alu_operand_loader_if #(.WIDTH(4), .SEL_W(4), .COUNT_W(8)) bus ();
    alu_operand_loader_if #(.WIDTH(4), .SEL_W(4), .COUNT_W(2)) bus2 ();

    assign bus2.din      = bus.din;
    assign bus2.load     = bus.load;
    assign bus2.abort    = bus.abort;
    assign bus2.op_ready = bus.op_ready;

    alu_operand_loader #(.WIDTH(4), .SEL_W(4), .COUNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_operand_loader #(.WIDTH(4), .SEL_W(4), .COUNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Behavioural model: how many fields are entered, whether an op is pending.
    int       m_entered;
    bit       m_pend;
    bit [3:0] m_vals [2];
    bit [3:0] m_a, m_b, m_sel;
    int       m_count;
    bit       m_over;

    function automatic void model_update();
        bit new_over;
        if (rst) begin
            m_entered = 0; m_pend = 0; m_vals[0] = 0; m_vals[1] = 0;
            m_a = 0; m_b = 0; m_sel = 0; m_count = 0; m_over = 0;
            return;
        end
        new_over = m_pend && bus.load;
        if (m_pend) begin
            if (bus.op_ready) begin
                m_pend  = 0;
                m_count = m_count + 1;
            end
        end else if (bus.abort) begin
            m_entered = 0;
        end else if (bus.load) begin
            if (m_entered < 2) begin
                m_vals[m_entered] = bus.din;
                m_entered = m_entered + 1;
            end else begin
                m_a = m_vals[0]; m_b = m_vals[1]; m_sel = bus.din;
                m_pend = 1; m_entered = 0;
            end
        end
        m_over = new_over;
    endfunction

    function automatic logic [26:0] expv();
        logic [1:0] ph;
        logic [7:0] c8;
        logic [1:0] c2;
        ph = m_pend ? 2'd3 : 2'(m_entered);
        c8 = 8'(m_count % 256);
        c2 = 2'(m_count % 4);
        return {m_pend, m_a, m_b, m_sel, ph, (ph != 2'd0), m_over, c8, c2};
    endfunction

    function automatic logic [26:0] obs();
        return {bus.op_valid, bus.a_out, bus.b_out, bus.sel_out, bus.phase,
                bus.busy, bus.overrun, bus.op_count, bus2.op_count};
    endfunction

    // stim layout: {rst, load, abort, op_ready, din[3:0]}
    task automatic apply_tick(input logic [7:0] s);
        {rst, bus.load, bus.abort, bus.op_ready, bus.din} = s;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        apply_tick(8'h80);
        n_total++;
        if (obs() !== 27'd0) $display("FAIL reset: got %h want 0", obs());
        else n_pass++;
        n_total++;
        if (obs() !== expv()) $display("FAIL reset_model: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] st [6] = '{8'h80, 8'h53, 8'h55, 8'h54, 8'h10, 8'h10};
        for (int i = 0; i < 6; i++) begin
            apply_tick(st[i]);
            n_total++;
            if (obs() !== expv()) $display("FAIL basic step %0d: got %h want %h", i, obs(), expv());
            else n_pass++;
            if (i == 3) begin
                n_total++;
                if ({bus.op_valid, bus.a_out, bus.b_out, bus.sel_out} !== 13'h1354)
                    $display("FAIL basic_issue: got %h want 1354",
                             {bus.op_valid, bus.a_out, bus.b_out, bus.sel_out});
                else n_pass++;
            end
            if (i == 4) begin
                n_total++;
                if ({bus.op_count, bus.phase, bus.op_valid} !== {8'd1, 2'd0, 1'b0})
                    $display("FAIL basic_done: got cnt %0d ph %0d v %b want 1 0 0",
                             bus.op_count, bus.phase, bus.op_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] st [11] = '{8'h80, 8'h43, 8'h45, 8'h44, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 11; i++) begin
            apply_tick(st[i]);
            n_total++;
            if (obs() !== expv()) $display("FAIL stall step %0d: got %h want %h", i, obs(), expv());
            else n_pass++;
            if (i >= 3 && i <= 8) begin
                n_total++;
                if ({bus.op_valid, bus.a_out, bus.b_out, bus.sel_out, bus.phase} !== 15'h1354 * 4 + 3)
                    $display("FAIL stall_hold step %0d: got v%b %h/%h/%h ph%0d want 1 3/5/4 ph3", i,
                             bus.op_valid, bus.a_out, bus.b_out, bus.sel_out, bus.phase);
                else n_pass++;
            end
        end
        n_total++;
        if ({bus.op_count, bus.phase} !== {8'd1, 2'd0})
            $display("FAIL stall_count: got cnt %0d ph %0d want 1 0", bus.op_count, bus.phase);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [7:0] st [12] = '{8'h80, 8'h49, 8'h20, 8'h41, 8'h42, 8'h47, 8'h10,
                                8'h61, 8'h41, 8'h42, 8'h47, 8'h20};
        for (int i = 0; i < 12; i++) begin
            apply_tick(st[i]);
            n_total++;
            if (obs() !== expv()) $display("FAIL abort step %0d: got %h want %h", i, obs(), expv());
            else n_pass++;
            if (i == 5) begin
                n_total++;
                if ({bus.a_out, bus.b_out, bus.sel_out} !== 12'h127)
                    $display("FAIL abort_ops: got %h want 127", {bus.a_out, bus.b_out, bus.sel_out});
                else n_pass++;
            end
            if (i == 7) begin
                n_total++;
                if (bus.phase !== 2'd0) $display("FAIL abort_load_same: got ph %0d want 0", bus.phase);
                else n_pass++;
            end
            if (i == 11) begin
                n_total++;
                if ({bus.op_valid, bus.phase} !== 3'b111)
                    $display("FAIL abort_in_issue: got v%b ph%0d want 1 3", bus.op_valid, bus.phase);
                else n_pass++;
            end
        end
        apply_tick(8'h10);
    endtask

    task automatic test_overrun();
        logic [7:0] st [13] = '{8'h80, 8'h41, 8'h42, 8'h43, 8'h4F, 8'h00, 8'h5F,
                                8'h00, 8'h46, 8'h47, 8'h48, 8'h10, 8'h00};
        logic       want_ov [13] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            apply_tick(st[i]);
            n_total++;
            if (obs() !== expv()) $display("FAIL overrun step %0d: got %h want %h", i, obs(), expv());
            else n_pass++;
            n_total++;
            if (bus.overrun !== want_ov[i])
                $display("FAIL overrun_pulse step %0d: got %b want %b", i, bus.overrun, want_ov[i]);
            else n_pass++;
            if (i == 4) begin
                n_total++;
                if ({bus.a_out, bus.b_out, bus.sel_out} !== 12'h123)
                    $display("FAIL overrun_ops: got %h want 123", {bus.a_out, bus.b_out, bus.sel_out});
                else n_pass++;
            end
            if (i == 10) begin
                n_total++;
                if ({bus.a_out, bus.b_out, bus.sel_out} !== 12'h678)
                    $display("FAIL overrun_next: got %h want 678", {bus.a_out, bus.b_out, bus.sel_out});
                else n_pass++;
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_tick(8'h80);
        for (int k = 0; k < 5; k++) begin
            apply_tick(8'h41);
            apply_tick(8'h42);
            apply_tick(8'h43);
            apply_tick(8'h10);
            n_total++;
            if (bus2.op_count !== want[k])
                $display("FAIL count_wrap op %0d: got %0d want %0d", k, bus2.op_count, want[k]);
            else n_pass++;
            n_total++;
            if (obs() !== expv()) $display("FAIL count_model op %0d: got %h want %h", k, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        apply_tick(8'h80);
        apply_tick(8'h41);
        apply_tick(8'h42);
        apply_tick(8'h80);
        n_total++;
        if (obs() !== 27'd0) $display("FAIL reset_in_sel: got %h want 0", obs());
        else n_pass++;
        apply_tick(8'h41);
        apply_tick(8'h42);
        apply_tick(8'h43);
        apply_tick(8'h10);
        apply_tick(8'h41);
        apply_tick(8'h42);
        apply_tick(8'h43);
        apply_tick(8'h80);
        n_total++;
        if (obs() !== 27'd0) $display("FAIL reset_in_issue: got %h want 0", obs());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] s;
        for (int i = 0; i < 600; i++) begin
            s[7]   = ($urandom_range(0, 49) == 0);
            s[6]   = $urandom_range(0, 1);
            s[5]   = ($urandom_range(0, 7) == 0);
            s[4]   = $urandom_range(0, 1);
            s[3:0] = 4'($urandom);
            apply_tick(s);
            n_total++;
            if (obs() !== expv()) $display("FAIL random step %0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        {rst, bus.load, bus.abort, bus.op_ready, bus.din} = 8'h80;
        m_entered = 0; m_pend = 0; m_vals[0] = 0; m_vals[1] = 0;
        m_a = 0; m_b = 0; m_sel = 0; m_count = 0; m_over = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_overrun();
        test_count_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
